// File: rtl/sn76489_seq_pkg.sv
// Shared types and byte encoders for the SN76489 bus sequencer.
package sn76489_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBuild,
      StStrobe,
      StRecover
   } seq_state_e;

   localparam logic       KIND_PERIOD = 1'b0;
   localparam logic       KIND_ATTEN  = 1'b1;
   localparam logic [1:0] CHAN_NOISE  = 2'd3;
   localparam int unsigned REQ_W      = 13;

   typedef struct packed {
      logic [1:0] chan;
      logic       kind;
      logic [9:0] data;
   } seq_req_t;

   function automatic logic [7:0] latch_byte(input logic [1:0] chan, input logic kind,
                                             input logic [3:0] val);
      return {1'b1, chan, kind, val};
   endfunction

   function automatic logic [7:0] data_byte(input logic [5:0] hi);
      return {2'b00, hi};
   endfunction

   function automatic logic [7:0] noise_byte(input logic [2:0] val);
      return {1'b1, CHAN_NOISE, 1'b0, 1'b0, val};
   endfunction

   // Value bits that actually reach the chip for a given request.
   function automatic logic [9:0] req_value(input seq_req_t req);
      if (req.kind == KIND_ATTEN) begin
         return {6'b0, req.data[3:0]};
      end else if (req.chan == CHAN_NOISE) begin
         return {7'b0, req.data[2:0]};
      end
      return req.data;
   endfunction

endpackage

// File: rtl/sn76489_seq_fifo.sv
// Request FIFO for the SN76489 bus sequencer; show-ahead read, full/empty/count status.
module sn76489_seq_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 13
) (
   input  logic                       clock_i,
   input  logic                       res_n_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clock_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clock_i or negedge res_n_i) begin
      if (!res_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sn76489_bus_sequencer.sv
// Queues register updates and strobes them into an SN76489 write port, paced on ready.
// Optional SN76489_SEQ_SHADOW_EN suppresses writes that repeat the last value written.
module sn76489_bus_sequencer
   import sn76489_seq_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned MIN_STROBE = 2,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic       clock_i,
   input  logic       res_n_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic [1:0] req_chan_i,
   input  logic       req_kind_i,
   input  logic [9:0] req_data_i,
   output logic       ce_n_o,
   output logic       we_n_o,
   output logic [7:0] d_o,
   input  logic       ready_i,
   output logic       busy_o,
   output logic       err_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(TIMEOUT + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam logic [SW-1:0] MIN_CNT = SW'(MIN_STROBE);
   localparam logic [SW-1:0] TO_CNT  = SW'(TIMEOUT);
   localparam logic [SW-1:0] ONE_CNT = SW'(1);
   localparam logic [GW-1:0] GAP_CNT = GW'(GAP_CYCLES);
   localparam logic [GW-1:0] ONE_GAP = GW'(1);

   seq_state_e    state_q;
   seq_req_t      cur_q, head_req, push_req;
   logic [7:0]    byte_d_q;
   logic          d_pend_q;
   logic [SW-1:0] strobe_cnt_q;
   logic [GW-1:0] gap_cnt_q;

   logic          fifo_full, fifo_empty, fifo_pop;
   logic [CW-1:0] fifo_count;
   logic [7:0]    l_byte, d_byte;
   logic          two_byte, strobe_ok, strobe_to, shadow_hit;

   assign push_req = '{chan: req_chan_i, kind: req_kind_i, data: req_data_i};
   assign fifo_pop = (state_q == StIdle);

   sn76489_seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REQ_W)
   ) u_fifo (
      .clock_i (clock_i),
      .res_n_i (res_n_i),
      .push_i  (req_valid_i),
      .wdata_i (push_req),
      .pop_i   (fifo_pop),
      .rdata_o (head_req),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign req_ready_o = ~fifo_full;
   assign busy_o      = (fifo_count != '0) || (state_q != StIdle);

   always_comb begin
      l_byte   = latch_byte(cur_q.chan, cur_q.kind, cur_q.data[3:0]);
      two_byte = 1'b0;
      if (cur_q.kind == KIND_PERIOD) begin
         if (cur_q.chan == CHAN_NOISE) begin
            l_byte = noise_byte(cur_q.data[2:0]);
         end else begin
            two_byte = 1'b1;
         end
      end
   end

   assign d_byte    = data_byte(cur_q.data[9:4]);
   assign strobe_ok = (state_q == StStrobe) && ready_i && (strobe_cnt_q >= MIN_CNT);
   assign strobe_to = (state_q == StStrobe) && (strobe_cnt_q == TO_CNT);

`ifdef SN76489_SEQ_SHADOW_EN
   logic [9:0] shadow_val_q [8];
   logic [7:0] shadow_vld_q;
   logic [2:0] cur_idx;
   logic [9:0] cur_val;

   assign cur_idx    = {cur_q.chan, cur_q.kind};
   assign cur_val    = req_value(cur_q);
   assign shadow_hit = shadow_vld_q[cur_idx] && (shadow_val_q[cur_idx] == cur_val);

   // Commit only when the final byte of the request is acknowledged.
   always_ff @(posedge clock_i or negedge res_n_i) begin
      if (!res_n_i) begin
         shadow_vld_q <= '0;
         for (int i = 0; i < 8; i++) begin
            shadow_val_q[i] <= '0;
         end
      end else if (strobe_ok && !d_pend_q) begin
         shadow_vld_q[cur_idx] <= 1'b1;
         shadow_val_q[cur_idx] <= cur_val;
      end
   end
`else
   assign shadow_hit = 1'b0;
`endif

   always_ff @(posedge clock_i or negedge res_n_i) begin
      if (!res_n_i) begin
         state_q      <= StIdle;
         cur_q        <= '0;
         byte_d_q     <= '0;
         d_pend_q     <= 1'b0;
         strobe_cnt_q <= '0;
         gap_cnt_q    <= '0;
         ce_n_o       <= 1'b1;
         we_n_o       <= 1'b1;
         d_o          <= 8'h00;
         err_o        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!fifo_empty) begin
                  cur_q   <= head_req;
                  state_q <= StBuild;
               end
            end
            StBuild: begin
               if (shadow_hit) begin
                  state_q <= StIdle;
               end else begin
                  byte_d_q     <= d_byte;
                  d_pend_q     <= two_byte;
                  d_o          <= l_byte;
                  ce_n_o       <= 1'b0;
                  we_n_o       <= 1'b0;
                  strobe_cnt_q <= ONE_CNT;
                  state_q      <= StStrobe;
               end
            end
            StStrobe: begin
               if (strobe_ok || strobe_to) begin
                  ce_n_o    <= 1'b1;
                  we_n_o    <= 1'b1;
                  gap_cnt_q <= ONE_GAP;
                  state_q   <= StRecover;
                  if (!strobe_ok) begin
                     err_o    <= 1'b1;
                     d_pend_q <= 1'b0;
                  end
               end else begin
                  strobe_cnt_q <= strobe_cnt_q + 1'b1;
               end
            end
            StRecover: begin
               if (gap_cnt_q >= GAP_CNT) begin
                  if (d_pend_q) begin
                     d_o          <= byte_d_q;
                     d_pend_q     <= 1'b0;
                     ce_n_o       <= 1'b0;
                     we_n_o       <= 1'b0;
                     strobe_cnt_q <= ONE_CNT;
                     state_q      <= StStrobe;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sn76489_bus_sequencer.sv
// Scoreboard bench for sn76489_bus_sequencer: expected strobe bytes queued at issue, checked by a monitor.
module tb_sn76489_bus_sequencer;

   logic       clock = 1'b0;
   logic       res_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_chan = '0;
   logic       req_kind = 1'b0;
   logic [9:0] req_data = '0;
   logic       ready = 1'b1;
   logic       req_ready, ce_n, we_n, busy, err;
   logic [7:0] d_out;

   typedef struct {
      logic [7:0] b;
      int         len;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   logic in_strobe = 1'b0;
   int   strobe_len = 0;
   exp_t cur_exp;

   always #5 clock = ~clock;

   sn76489_bus_sequencer #(
      .DEPTH      (4),
      .MIN_STROBE (2),
      .GAP_CYCLES (2),
      .TIMEOUT    (16)
   ) dut (
      .clock_i     (clock),
      .res_n_i     (res_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_chan_i  (req_chan),
      .req_kind_i  (req_kind),
      .req_data_i  (req_data),
      .ce_n_o      (ce_n),
      .we_n_o      (we_n),
      .d_o         (d_out),
      .ready_i     (ready),
      .busy_o      (busy),
      .err_o       (err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // len 0 means the strobe length is not checked (ready timing driven externally).
   task automatic expect_byte(input logic [7:0] b, input int len);
      exp_t e;
      e.b = b;
      e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [1:0] c, input logic k, input logic [9:0] d);
      int n = 0;
      req_chan  = c;
      req_kind  = k;
      req_data  = d;
      req_valid = 1'b1;
      while (!req_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) check("push_ready_timeout", {31'b0, req_ready}, 32'd1);
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || exp_q.size() != 0 || in_strobe) && n < 500) begin
         @(negedge clock);
         n++;
      end
      check({name, "_busy"}, {31'b0, busy}, 32'd0);
      check({name, "_drained"}, exp_q.size(), 32'd0);
   endtask

   // Monitor: compare each strobe's byte at its start and its length at its end.
   initial begin
      forever begin
         @(negedge clock);
         if (!res_n) begin
            in_strobe = 1'b0;
         end else if (!ce_n) begin
            if (!in_strobe) begin
               in_strobe  = 1'b1;
               strobe_len = 1;
               check("we_n_with_ce_n", {31'b0, we_n}, 32'd0);
               if (exp_q.size() == 0) begin
                  check("strobe_expected", exp_q.size(), 32'd1);
                  cur_exp.b = d_out;
                  cur_exp.len = 0;
               end else begin
                  cur_exp = exp_q.pop_front();
                  check("strobe_byte", {24'b0, d_out}, {24'b0, cur_exp.b});
               end
            end else begin
               strobe_len++;
            end
         end else if (in_strobe) begin
            in_strobe = 1'b0;
            if (cur_exp.len != 0) check("strobe_len", strobe_len, cur_exp.len);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      #12;
      check("rst_ce_n", {31'b0, ce_n}, 32'd1);
      check("rst_we_n", {31'b0, we_n}, 32'd1);
      check("rst_d", {24'b0, d_out}, 32'h00);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      @(negedge clock);
      res_n = 1'b1;
      @(negedge clock);

      // Tone: latch then data byte.
      expect_byte(8'h8B, 2);
      expect_byte(8'h1A, 2);
      send(2'd0, 1'b0, 10'h1AB);
      wait_idle("tone");

      // Attenuation with junk upper bits.
      expect_byte(8'hDD, 2);
      send(2'd2, 1'b1, 10'h0FD);
      wait_idle("atten");

      // Noise: bits 9:3 ignored.
      expect_byte(8'hE5, 2);
      send(2'd3, 1'b0, 10'h3FD);
      wait_idle("noise");

      // Backpressure: first request stalls in strobe, four more fill the FIFO.
      ready = 1'b0;
      expect_byte(8'hB1, 0);
      expect_byte(8'hA4, 2);
      expect_byte(8'h2F, 2);
      expect_byte(8'h9A, 2);
      expect_byte(8'hF2, 2);
      expect_byte(8'hE6, 2);
      send(2'd1, 1'b1, 10'h001);
      send(2'd1, 1'b0, 10'h2F4);
      send(2'd0, 1'b1, 10'h00A);
      send(2'd3, 1'b1, 10'h002);
      send(2'd3, 1'b0, 10'h006);
      check("bp_full_ready", {31'b0, req_ready}, 32'd0);
      check("bp_busy", {31'b0, busy}, 32'd1);
      ready = 1'b1;
      wait_idle("bp");
      check("bp_no_err", {31'b0, err}, 32'd0);

      // Timeout on a two-byte write: the data byte is discarded.
      ready = 1'b0;
      expect_byte(8'hC7, 16);
      send(2'd2, 1'b0, 10'h3C7);
      n = 0;
      while (!err && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("timeout_err", {31'b0, err}, 32'd1);
      check("timeout_release", {31'b0, ce_n}, 32'd1);
      ready = 1'b1;
      wait_idle("timeout");
      expect_byte(8'hC7, 2);
      expect_byte(8'h3C, 2);
      send(2'd2, 1'b0, 10'h3C7);
      wait_idle("after_timeout");
      check("err_sticky", {31'b0, err}, 32'd1);

      // Repeated attenuation write.
      expect_byte(8'h97, 2);
`ifndef SN76489_SEQ_SHADOW_EN
      expect_byte(8'h97, 2);
`endif
      send(2'd0, 1'b1, 10'h007);
      send(2'd0, 1'b1, 10'h007);
      wait_idle("repeat");

      // Reset mid-strobe with a second request queued behind it.
      ready = 1'b0;
      expect_byte(8'hFF, 0);
      send(2'd3, 1'b1, 10'h00F);
      send(2'd0, 1'b0, 10'h1AB);
      n = 0;
      while (ce_n && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("mid_strobe_active", {31'b0, ce_n}, 32'd0);
      #2;
      res_n = 1'b0;
      #1;
      check("mid_rst_ce_n", {31'b0, ce_n}, 32'd1);
      check("mid_rst_we_n", {31'b0, we_n}, 32'd1);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("mid_rst_err", {31'b0, err}, 32'd0);
      @(negedge clock);
      res_n = 1'b1;
      ready = 1'b1;
      repeat (20) @(negedge clock);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
      check("post_rst_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
